// File: rtl/muldiv_seq_if.sv
// Pipeline-side bundle for the iterative multiply/divide sequencer.
// Carries the EX-stage request, the shared-ALU loop and the result/stall signals.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_own;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             illegal;

  // The pipeline drives requests and returns the shared ALU output.
  modport master (
    output start, funct3, src_a, src_b, alu_result,
    input  alu_own, alu_a, alu_b, alu_ctrl, stall, done, result, illegal
  );

  modport slave (
    input  start, funct3, src_a, src_b, alu_result,
    output alu_own, alu_a, alu_b, alu_ctrl, stall, done, result, illegal
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MUL/DIV/DIVU/REM/REMU sequencer that borrows the EX-stage add/sub ALU.
// Optional macro MULDIV_DBZ_FAST_EN: divide/remainder by zero skips the ITER phase.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset_n,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;       // multiplicand, or dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] r_b;       // multiplier, or divisor
  logic [WIDTH-1:0] r_acc;     // product accumulator, or partial remainder
  logic [WIDTH-1:0] r_src_a;
  logic [WIDTH-1:0] r_result;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_done;
  logic             r_illegal;

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic             w_is_rem;
  logic             w_illegal_op;
  logic             w_div_zero;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_shift;
  logic [WIDTH-1:0] w_fix;
  logic             w_alu_own;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic [2:0]       w_alu_ctrl;

  assign w_is_mul     = (r_op == 3'b000);
  assign w_is_div     = r_op[2];
  assign w_signed     = r_op[2] & ~r_op[0];
  assign w_is_rem     = r_op[1];
  assign w_illegal_op = ~r_op[2] & (r_op != 3'b000);
  assign w_div_zero   = (r_b == '0);
  assign w_rem_shift  = {r_acc[WIDTH-2:0], r_a[WIDTH-1]};
  assign w_borrow     = (w_rem_shift < r_b);

  // Signed overflow (MIN / -1) falls out of the magnitude divide: |MIN|/1 = MIN, rem 0.
  always_comb begin
    w_fix = r_acc;
    if (w_is_div) begin
      if (w_div_zero)    w_fix = w_is_rem ? r_src_a : '1;
      else if (w_is_rem) w_fix = r_sign_r ? -r_acc : r_acc;
      else               w_fix = r_sign_q ? -r_a : r_a;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_alu_own  = 1'b0;
    w_alu_a    = '0;
    w_alu_b    = '0;
    w_alu_ctrl = 3'b000;
    if (r_state == S_ITER) begin
      w_alu_own = 1'b1;
      if (w_is_mul) begin
        if (r_b[0]) begin
          w_alu_a = r_acc;
          w_alu_b = r_a;
        end
      end else begin
        w_alu_a    = w_rem_shift;
        w_alu_b    = r_b;
        w_alu_ctrl = 3'b001;
      end
    end
  end

  assign bus.alu_own  = w_alu_own;
  assign bus.alu_a    = w_alu_a;
  assign bus.alu_b    = w_alu_b;
  assign bus.alu_ctrl = w_alu_ctrl;
  assign bus.stall    = (r_state inside {S_PREP, S_ITER, S_FIXUP}) | ((r_state == S_IDLE) & bus.start);
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.illegal  = r_illegal;

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and clears every register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_src_a   <= '0;
      r_result  <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.funct3;
            r_a     <= bus.src_a;
            r_b     <= bus.src_b;
            r_src_a <= bus.src_a;
            r_acc   <= '0;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_cnt    <= CW'(WIDTH);
          r_sign_q <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_sign_r <= w_signed & r_a[WIDTH-1];
          if (w_signed) begin
            r_a <= r_a[WIDTH-1] ? -r_a : r_a;
            r_b <= r_b[WIDTH-1] ? -r_b : r_b;
          end
          if (w_illegal_op) begin
            r_result  <= '0;
            r_done    <= 1'b1;
            r_illegal <= 1'b1;
            r_state   <= S_DONE;
`ifdef MULDIV_DBZ_FAST_EN
          end else if (w_is_div && w_div_zero) begin
            r_state <= S_FIXUP;
`else
`endif
          end else begin
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_is_mul) begin
            if (r_b[0]) r_acc <= bus.alu_result;
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
          end else begin
            r_acc <= w_borrow ? w_rem_shift : bus.alu_result;
            r_a   <= {r_a[WIDTH-2:0], ~w_borrow};
          end
          if (r_cnt == CW'(1)) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          r_result <= w_fix;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done    <= 1'b0;
          r_illegal <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic reference model, timing and ALU-sharing checks.
// Honours MULDIV_DBZ_FAST_EN for the expected divide-by-zero latency.
module tb_muldiv_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] last_result = '0;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Shared add/sub ALU of the EX stage.
  assign bus.alu_result = (bus.alu_ctrl == 3'b001) ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // RISC-V M-extension results from plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    case (f)
      3'b000: r = a * b;
      3'b100: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      3'b111: r = (b == 0) ? a : a % b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] b);
    if (f inside {3'b001, 3'b010, 3'b011}) return 2;
`ifdef MULDIV_DBZ_FAST_EN
    if (f[2] && b == 0) return 3;
`endif
    return W + 3;
  endfunction

  // Issue one op the cycle after the previous DONE and follow it cycle by cycle until done.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit has_lit, input logic [31:0] lit, input string tag);
    logic [31:0] exp;
    int lat, own_cnt, own_exp, stall_err, idle_alu_err;
    bit  seen;
    exp     = ref_result(f, a, b);
    lat     = ref_latency(f, b);
    own_exp = (lat == W + 3) ? W : 0;
    if (has_lit) check({tag, " model"}, exp, lit);
    @(posedge clk); #1;
    check({tag, " result hold"}, bus.result, last_result);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.src_a  = a;
    bus.src_b  = b;
    #1;
    check({tag, " stall on start"}, {31'b0, bus.stall}, 32'd1);
    own_cnt = 0; stall_err = 0; idle_alu_err = 0; seen = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus.alu_own) own_cnt++;
      else if (bus.alu_a != 0 || bus.alu_b != 0 || bus.alu_ctrl != 0) idle_alu_err++;
      if (bus.stall !== (n < lat)) stall_err++;
      if (bus.done) begin
        seen = 1;
        bus.start = 1'b0;
        check({tag, " latency"}, 32'(n + 1), 32'(lat + 1));
        check({tag, " result"}, bus.result, exp);
        check({tag, " illegal"}, {31'b0, bus.illegal}, {31'b0, (f inside {3'b001, 3'b010, 3'b011})});
        check({tag, " alu_own cycles"}, 32'(own_cnt), 32'(own_exp));
        check({tag, " stall profile"}, 32'(stall_err), 32'd0);
        check({tag, " idle alu drive"}, 32'(idle_alu_err), 32'd0);
        last_result = exp;
        break;
      end
    end
    if (!seen) begin
      check({tag, " done timeout"}, 32'd0, 32'd1);
      bus.start = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " alu_own"},  {31'b0, bus.alu_own}, 32'd0);
    check({tag, " alu_a"},    bus.alu_a, 32'd0);
    check({tag, " alu_b"},    bus.alu_b, 32'd0);
    check({tag, " alu_ctrl"}, {29'b0, bus.alu_ctrl}, 32'd0);
    check({tag, " stall"},    {31'b0, bus.stall}, 32'd0);
    check({tag, " done"},     {31'b0, bus.done}, 32'd0);
    check({tag, " result"},   bus.result, 32'd0);
    check({tag, " illegal"},  {31'b0, bus.illegal}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f;
    logic [31:0] a, b;
    int extra_done;
    bus.start = 1'b0; bus.funct3 = '0; bus.src_a = '0; bus.src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    do_op(3'b000, 32'd7, 32'd6, 1, 32'd42, "mul 7*6");
    do_op(3'b100, 32'hFFFF_FFEC, 32'd3, 1, 32'hFFFF_FFFA, "div -20/3");
    do_op(3'b110, 32'hFFFF_FFEC, 32'd3, 1, 32'hFFFF_FFFE, "rem -20%3");
    do_op(3'b101, 32'd100, 32'd0, 1, 32'hFFFF_FFFF, "divu 100/0");
    do_op(3'b111, 32'd100, 32'd0, 1, 32'd100, "remu 100%0");
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div ovf");
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, "rem ovf");
    do_op(3'b000, 32'h8000_0000, 32'd2, 1, 32'h0, "mul wrap");
    do_op(3'b100, 32'hFFFF_FFEC, 32'd0, 1, 32'hFFFF_FFFF, "div -20/0");
    do_op(3'b110, 32'hFFFF_FFEC, 32'd0, 1, 32'hFFFF_FFEC, "rem -20%0");

    // Reset during ITER cycle 10 of a MUL: no done, all outputs cleared.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.src_a = 32'h1234_5678; bus.src_b = 32'h0F0F_0F0F;
    repeat (11) @(posedge clk);
    #1;
    check("mid-iter alu_own", {31'b0, bus.alu_own}, 32'd1);
    reset_n = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check_all_zero("mid-iter reset");
    reset_n = 1'b1;
    extra_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.stall) extra_done++;
    end
    check("no done after reset", 32'(extra_done), 32'd0);
    last_result = 32'd0;
    do_op(3'b000, 32'd3, 32'd5, 1, 32'd15, "mul 3*5");

    do_op(3'b001, 32'd11, 32'd22, 1, 32'd0, "illegal 001");
    do_op(3'b101, 32'd9, 32'd2, 1, 32'd4, "divu 9/2");
    do_op(3'b011, 32'hDEAD_BEEF, 32'd1, 0, 32'd0, "illegal 011");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    f = 3'b000;
        2, 3:    f = 3'b100;
        4:       f = 3'b101;
        5, 6:    f = 3'b110;
        7, 8:    f = 3'b111;
        default: f = 3'($urandom_range(1, 3));
      endcase
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = b >> $urandom_range(8, 31);
        default: ;
      endcase
      do_op(f, a, b, 0, 32'd0, $sformatf("rand%0d f%0d", i, f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the EX stage of the 5-stage RV32 pipeline.
- Time-shares the existing add/sub ALU. While busy it drives the ALU operands and ALUControl (000 add, 001 sub) through the EX-stage operand mux.
- Stalls the pipeline until the result is ready.
- Supports MUL (low word), DIV, DIVU, REM, REMU.

Parameters:
- WIDTH, 32, operand/result width; iteration count = WIDTH.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  EX holds an M-extension op (opcode 0110011, funct7=0000001)
- funct3  in  3  000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src_a  in  WIDTH  rs1 value (multiplicand/dividend)
- src_b  in  WIDTH  rs2 value (multiplier/divisor)
- alu_result  in  WIDTH  shared ALU output
- alu_own  out  1  EX operand mux selects alu_a/alu_b/alu_ctrl
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_ctrl  out  3  ALUControl to shared ALU
- stall  out  1  freeze PC/IF/ID/EX registers
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  product/quotient/remainder
- illegal  out  1  one-cycle pulse with done for funct3 001/010/011

Behaviour:
- Reset (reset_n=0 at a clk edge) values:
  - All outputs 0; state IDLE; counter 0; internal registers 0.
  - Reset wins over any in-flight operation. It is sampled every cycle, including mid-ITER; the operation is discarded with no done pulse.
- States: IDLE -> PREP -> ITER -> FIXUP -> DONE -> IDLE.
- IDLE:
  - start=1 captures funct3, src_a, src_b and goes to PREP.
  - stall = start (combinational) in IDLE.
- PREP (1 cycle):
  - Signed DIV/REM: register |src_a| and |src_b|, and record sign_q = a[W-1]^b[W-1] and sign_r = a[W-1].
  - Unsigned ops and MUL: operands are used as-is.
  - Counter loads WIDTH.
  - funct3 001/010/011 go straight to DONE with result 0 and illegal=1.
- ITER (WIDTH cycles, counter decrements to 0):
  - alu_own=1 in ITER only.
  - MUL, shift-add:
    - If multiplier LSB=1, alu_a=acc, alu_b=multiplicand, alu_ctrl=000, and acc takes alu_result.
    - Then the multiplicand shifts left 1 and the multiplier shifts right 1.
    - Only the low WIDTH bits are kept (wrap-around).
  - DIV/REM, restoring:
    - rem_shift = {rem[W-2:0], dividend MSB}.
    - alu_a=rem_shift, alu_b=divisor, alu_ctrl=001.
    - Borrow is computed internally as rem_shift < divisor (unsigned compare).
    - No borrow: rem takes alu_result and quotient bit = 1. Borrow: rem takes rem_shift and quotient bit = 0.
  - Exit to FIXUP when counter reaches 0.
- FIXUP (1 cycle):
  - Signed ops: negate quotient if sign_q, negate remainder if sign_r.
  - Divisor = 0 (RISC-V spec values): quotient = all ones, remainder = original src_a (signed and unsigned).
  - Signed overflow (src_a = 0x8000_0000, src_b = -1): quotient = 0x8000_0000, remainder = 0.
- DONE (1 cycle):
  - done=1 and result valid.
  - stall=0 so EX advances and captures result.
  - Next state is IDLE.
  - result holds its value until the next operation's DONE.
- stall = (state in PREP, ITER, FIXUP) | (state==IDLE & start).
- Latency: start sampled at edge t gives done high in cycle t+WIDTH+3 (WIDTH=32: 35 cycles).
- start while not IDLE is ignored (the pipeline is frozen, so it stays asserted).
- Back-to-back: start=1 in the cycle after DONE begins a new operation.
- Outside ITER, alu_a, alu_b and alu_ctrl are 0/0/000.

Optional Feature:
- Macro: MULDIV_DBZ_FAST_EN.
- Defined: a divide/remainder with src_b=0 goes PREP -> FIXUP, skipping ITER. done arrives at t+3 with the same spec values.
- Undefined: fixed latency WIDTH+3 for every legal op.

Test Plan:
- MUL src_a=7, src_b=6 -> done at t+35, result=42, stall high t..t+34, alu_own high exactly 32 cycles.
- DIV src_a=-20 (0xFFFF_FFEC), src_b=3 -> result=0xFFFF_FFFA (-6); REM same operands -> 0xFFFF_FFFE (-2).
- DIVU src_a=100, src_b=0 -> result=0xFFFF_FFFF; REMU -> 100. Latency is 35, or 3 with MULDIV_DBZ_FAST_EN.
- DIV src_a=0x8000_0000, src_b=0xFFFF_FFFF -> 0x8000_0000; REM -> 0. MUL 0x8000_0000*2 -> 0 (wrap).
- reset_n=0 at ITER cycle 10 of a MUL -> next cycle all outputs 0, state IDLE, no done pulse. A following MUL 3*5 -> 15.
- funct3=001 -> done and illegal pulse at t+2, result=0. Then DIVU 9/2 started the cycle after -> result=4.
